snake_step_engine: RTL and testbench
====================================

// Module: snake_step_engine
// PURPOSE
//  Parametrised N-player snake game core: on each game tick, advances every live snake one cell, then checks walls, bodies and food.
//  Collision and food checks run as a sequential per-segment scan, not a wide combinational compare, so NUM_SNAKES and MAX_LEN scale.
//  Sits between the key decoders / tick divider and the VGA renderer; outputs use the packed {y,x} segment-bus format the renderer consumes.
// PARAMETERS
//  NUM_SNAKES  2   number of snakes (1..4)
//  NUM_FOOD    2   number of food items (1..4)
//  MAX_LEN     31  segments per snake
//  NUM_LEN     10  bits per position: {y[NUM_LEN/2-1:0], x[NUM_LEN/2-1:0]}; all-ones = empty slot
//  LEN_BITS    5   width of each length field
//  WIDTH       32  grid columns
//  HEIGHT      24  grid rows; NUM_SNAKES*3+2 <= HEIGHT is required
// PORTS
//  clk        in   1                     system clock
//  rst        in   1                     synchronous, active-high reset
//  tick       in   1                     one-cycle game-step request
//  pause      in   1                     1 = ignore ticks
//  dir_valid  in   NUM_SNAKES            per-snake direction update strobe
//  dir_in     in   2*NUM_SNAKES          per-snake direction: 00 up, 01 down, 10 left, 11 right
//  snakes     out  NUM_SNAKES*MAX_LEN*NUM_LEN  segment buses; segment 0 = head, in the LSBs
//  lens       out  NUM_SNAKES*LEN_BITS   current lengths, which are also the scores
//  foods      out  NUM_FOOD*NUM_LEN      food positions
//  alive      out  NUM_SNAKES            1 = snake still moving
//  busy       out  1                     step in progress
//  step_done  out  1                     one-cycle pulse when a step finishes
//  game_over  out  1                     1 when alive == 0
// BEHAVIOUR
//  Reset values
//   - snake i: head (x=3, y=2+3i), seg1 (x=2, y=2+3i), rest all-ones; len 2; dir right; alive 1.
//   - food j: (x=WIDTH-4, y=3+3j); busy 0; step_done 0; LFSR 16'hACE1.
//   - rst in any state, including mid-step, aborts the step and restores all reset values next cycle.
//  Direction register per snake
//   - Loaded from dir_in when dir_valid, in any state.
//   - A request that exactly reverses the current dir is dropped.
//   - Sampled only in MOVE.
//  16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle after reset.
//  FSM
//   - IDLE -> MOVE on tick && !pause. A tick while busy or paused is dropped; ticks are not queued.
//   - MOVE (1 cycle), live snakes only:
//     - New head = head +/- 1 on the selected axis.
//     - tail_save[i] <= seg[len-1]; seg[k] <= seg[k-1]; seg[0] <= new head.
//     - Slots at index >= len are set to all-ones.
//     - Off-grid head (x>=WIDTH, y>=HEIGHT, or underflow): snake is not moved and alive[i] <= 0.
//   - CHECK (MAX_LEN cycles, k = 0..MAX_LEN-1):
//     - Each live head is compared with seg[k] of every snake, dead ones included. Own seg[0] is excluded; all-ones slots never match.
//     - Any match clears alive[i] at FEED entry. Head-to-head: both snakes die.
//   - FEED:
//     - For each snake alive after CHECK whose head equals food j: if len < MAX_LEN, seg[len] <= tail_save and len++; if len == MAX_LEN, len saturates.
//     - Every eaten food is replaced. Candidate = {lfsr[9:5], lfsr[4:0]}; accepted only if x<WIDTH, y<HEIGHT and it matches no head or other food.
//     - One food replaced per cycle, lowest j first; FEED stays until all eaten foods are replaced.
//     - Two snakes never eat the same food, because equal heads already killed both.
//   - DONE -> IDLE: step_done = 1 for exactly one cycle.
//  Latency and status
//   - Tick at cycle t: busy = 1 from t+1 until the step_done cycle inclusive.
//   - Step with no food eaten: step_done at t+MAX_LEN+3.
//  Dead snakes keep their segments (still drawn and still obstacles) and never move again.
//  game_over is combinational from alive. Ticks are still accepted after game over, but nothing moves.
//  Arithmetic: lens saturate at MAX_LEN; coordinate compares are unsigned and NUM_LEN/2 bits wide.
// CONFIGURATION
//  WRAP_EN defined:
//   - Heads wrap: x = -1 -> WIDTH-1, x = WIDTH -> 0, same for y.
//   - Walls never kill; only body or head collisions do.
//  WRAP_EN undefined: an off-grid move kills the snake as described in MOVE.
// TESTING
//  T1 reset, no dir change, tick -> snake0 head (4,2) seg1 (3,2), len 2; step_done exactly MAX_LEN+3 cycles after tick; busy high throughout.
//  T2 food0 forced to (4,2), tick -> snake0 len 3 with seg2 (2,2); food0 moves to an in-grid cell that is not (4,2); score output lens[4:0]=3.
//  T3 snake0 heading right from x=WIDTH-1: no WRAP_EN -> alive[0]=0, head stays (31,y); with WRAP_EN -> head (0,y), alive[0]=1.
//  T4 snakes 0 and 1 steered into the same cell -> both alive bits clear; game_over=1 for NUM_SNAKES=2; further ticks change no segment.
//  T5 dir right then dir_valid with left -> left dropped, head moves right; tick pulses during busy and while pause=1 -> no extra steps.
//  T6 rst asserted mid-CHECK -> next cycle all outputs at reset values, busy=0, no step_done pulse.

Source files
------------

// File: rtl/snake_step_engine.sv
// snake_step_engine: N-player snake game core. Each tick moves every live snake, then a per-segment scan finds collisions and food.
// Optional build macro WRAP_EN: heads wrap at the grid edges instead of dying at walls.
module snake_step_engine #(
  parameter int NUM_SNAKES = 2,
  parameter int NUM_FOOD   = 2,
  parameter int MAX_LEN    = 31,
  parameter int NUM_LEN    = 10,
  parameter int LEN_BITS   = 5,
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 24
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  tick,
  input  logic                                  pause,
  input  logic [NUM_SNAKES-1:0]                 dir_valid,
  input  logic [2*NUM_SNAKES-1:0]               dir_in,
  output logic [NUM_SNAKES*MAX_LEN*NUM_LEN-1:0] snakes,
  output logic [NUM_SNAKES*LEN_BITS-1:0]        lens,
  output logic [NUM_FOOD*NUM_LEN-1:0]           foods,
  output logic [NUM_SNAKES-1:0]                 alive,
  output logic                                  busy,
  output logic                                  step_done,
  output logic                                  game_over
);
  localparam int CW  = NUM_LEN / 2;
  localparam int CW1 = CW + 1;
  localparam int KW  = $clog2(MAX_LEN + 1);
  localparam logic [NUM_LEN-1:0]  EMPTY     = '1;
  localparam logic [CW:0]         GRID_W    = CW1'(WIDTH);
  localparam logic [CW:0]         GRID_H    = CW1'(HEIGHT);
  localparam logic [CW:0]         ONE       = CW1'(1);
  localparam logic [LEN_BITS-1:0] LEN_ONE   = LEN_BITS'(1);
  localparam logic [LEN_BITS-1:0] LEN_MAX   = LEN_BITS'(MAX_LEN);
  localparam logic [KW-1:0]       K_LAST    = KW'(MAX_LEN - 1);
  localparam logic [1:0] D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_CHECK, S_FEED, S_DONE} state_t;

  state_t              state;
  logic [NUM_LEN-1:0]  seg       [NUM_SNAKES][MAX_LEN];
  logic [NUM_LEN-1:0]  tail_save [NUM_SNAKES];
  logic [NUM_LEN-1:0]  food      [NUM_FOOD];
  logic [LEN_BITS-1:0] len       [NUM_SNAKES];
  logic [1:0]          dir       [NUM_SNAKES];
  logic [15:0]         lfsr;
  logic [KW-1:0]       k;
  logic [NUM_SNAKES-1:0] hit, hit_now, off_grid, eat_snake;
  logic [NUM_FOOD-1:0]   pending, eat_food, sel_mask;
  logic                  feed_first, cand_ok;
  logic [NUM_LEN-1:0]    cand;
  logic [NUM_LEN-1:0]    new_head [NUM_SNAKES];
  logic [CW:0]           hx [NUM_SNAKES], hy [NUM_SNAKES], nx [NUM_SNAKES], ny [NUM_SNAKES];

  // Coordinates carry one spare bit so that +1 past the edge and -1 below zero both land >= the grid size.
  // NOTE: every signal written in an always_comb gets a default first, so no path can leave it holding a value (no latch).
  always_comb begin
    for (int i = 0; i < NUM_SNAKES; i++) begin
      hx[i] = {1'b0, seg[i][0][CW-1:0]};
      hy[i] = {1'b0, seg[i][0][NUM_LEN-1:CW]};
      nx[i] = hx[i];
      ny[i] = hy[i];
      case (dir[i])
        D_UP:    ny[i] = hy[i] - ONE;
        D_DOWN:  ny[i] = hy[i] + ONE;
        D_LEFT:  nx[i] = hx[i] - ONE;
        default: nx[i] = hx[i] + ONE;
      endcase
`ifdef WRAP_EN
      if (nx[i] >= GRID_W) nx[i] = (dir[i] == D_LEFT) ? GRID_W - ONE : '0;
      if (ny[i] >= GRID_H) ny[i] = (dir[i] == D_UP)   ? GRID_H - ONE : '0;
      off_grid[i] = 1'b0;
`else
      off_grid[i] = (nx[i] >= GRID_W) || (ny[i] >= GRID_H);
`endif
      new_head[i] = {ny[i][CW-1:0], nx[i][CW-1:0]};
    end
  end

  always_comb begin
    hit_now = '0;
    for (int i = 0; i < NUM_SNAKES; i++)
      for (int s = 0; s < NUM_SNAKES; s++)
        if (alive[i] && !(s == i && k == '0) && seg[s][k] != EMPTY && seg[s][k] == seg[i][0])
          hit_now[i] = 1'b1;
  end

  always_comb begin
    eat_snake = '0;
    eat_food  = '0;
    for (int i = 0; i < NUM_SNAKES; i++)
      for (int j = 0; j < NUM_FOOD; j++)
        if (alive[i] && seg[i][0] == food[j]) begin
          eat_snake[i] = 1'b1;
          eat_food[j]  = 1'b1;
        end
  end

  assign sel_mask = pending & (~pending + NUM_FOOD'(1));

  always_comb begin
    cand    = lfsr[NUM_LEN-1:0];
    cand_ok = ({1'b0, cand[CW-1:0]} < GRID_W) && ({1'b0, cand[NUM_LEN-1:CW]} < GRID_H);
    for (int i = 0; i < NUM_SNAKES; i++)
      if (cand == seg[i][0]) cand_ok = 1'b0;
    for (int j = 0; j < NUM_FOOD; j++)
      if (!sel_mask[j] && cand == food[j]) cand_ok = 1'b0;
  end

  // NOTE: all state here uses non-blocking assignments, so every read sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      step_done  <= 1'b0;
      lfsr       <= 16'hACE1;
      k          <= '0;
      hit        <= '0;
      pending    <= '0;
      feed_first <= 1'b0;
      alive      <= '1;
      // NOTE: the whole segment store is reset because the renderer draws it directly and all-ones marks an empty slot.
      for (int i = 0; i < NUM_SNAKES; i++) begin
        for (int kk = 2; kk < MAX_LEN; kk++) seg[i][kk] <= EMPTY;
        seg[i][0]    <= {CW'(2 + 3 * i), CW'(3)};
        seg[i][1]    <= {CW'(2 + 3 * i), CW'(2)};
        tail_save[i] <= EMPTY;
        len[i]       <= LEN_BITS'(2);
        dir[i]       <= D_RIGHT;
      end
      for (int j = 0; j < NUM_FOOD; j++) food[j] <= {CW'(3 + 3 * j), CW'(WIDTH - 4)};
    end else begin
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      step_done <= 1'b0;
      for (int i = 0; i < NUM_SNAKES; i++)
        if (dir_valid[i] && dir_in[2*i +: 2] != (dir[i] ^ 2'b01)) dir[i] <= dir_in[2*i +: 2];

      case (state)
        S_IDLE: if (tick && !pause) begin
          state <= S_MOVE;
          busy  <= 1'b1;
        end
        S_MOVE: begin
          for (int i = 0; i < NUM_SNAKES; i++)
            if (alive[i]) begin
              if (off_grid[i]) alive[i] <= 1'b0;
              else begin
                tail_save[i] <= seg[i][len[i] - LEN_ONE];
                seg[i][0]    <= new_head[i];
                for (int kk = 1; kk < MAX_LEN; kk++)
                  seg[i][kk] <= (LEN_BITS'(kk) < len[i]) ? seg[i][kk-1] : EMPTY;
              end
            end
          k     <= '0;
          hit   <= '0;
          state <= S_CHECK;
        end
        S_CHECK: begin
          hit <= hit | hit_now;
          if (k == K_LAST) begin
            alive      <= alive & ~(hit | hit_now);
            feed_first <= 1'b1;
            state      <= S_FEED;
          end else k <= k + KW'(1);
        end
        S_FEED: begin
          feed_first <= 1'b0;
          if (feed_first) begin
            for (int i = 0; i < NUM_SNAKES; i++)
              if (eat_snake[i] && len[i] < LEN_MAX) begin
                seg[i][len[i]] <= tail_save[i];
                len[i]         <= len[i] + LEN_ONE;
              end
            pending <= eat_food;
            if (eat_food == '0) begin
              state     <= S_DONE;
              step_done <= 1'b1;
            end
          end else if (cand_ok) begin
            // Replace the lowest pending food; retry next cycle with a fresh LFSR value otherwise.
            for (int j = 0; j < NUM_FOOD; j++)
              if (sel_mask[j]) food[j] <= cand;
            pending <= pending & ~sel_mask;
            if ((pending & ~sel_mask) == '0) begin
              state     <= S_DONE;
              step_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SNAKES; i++) begin : g_snake_out
    for (genvar kk = 0; kk < MAX_LEN; kk++) begin : g_seg_out
      assign snakes[(i*MAX_LEN+kk)*NUM_LEN +: NUM_LEN] = seg[i][kk];
    end
    assign lens[i*LEN_BITS +: LEN_BITS] = len[i];
  end
  for (genvar j = 0; j < NUM_FOOD; j++) begin : g_food_out
    assign foods[j*NUM_LEN +: NUM_LEN] = food[j];
  end

  assign game_over = ~|alive;
endmodule

// File: tb/tb_snake_step_engine.sv
// Self-checking bench for snake_step_engine: directed steps with a head/length/alive scoreboard fed by a small game model.
module tb_snake_step_engine;
  localparam int NS = 2, NF = 2, ML = 31, NL = 10, LB = 5, W = 32, H = 24;
  localparam int STEP_LAT = ML + 3;

  logic clk = 1'b0;
  logic rst, tick, pause;
  logic [NS-1:0]      dir_valid;
  logic [2*NS-1:0]    dir_in;
  logic [NS*ML*NL-1:0] snakes;
  logic [NS*LB-1:0]   lens;
  logic [NF*NL-1:0]   foods;
  logic [NS-1:0]      alive;
  logic               busy, step_done, game_over;

  snake_step_engine #(
    .NUM_SNAKES(NS), .NUM_FOOD(NF), .MAX_LEN(ML), .NUM_LEN(NL),
    .LEN_BITS(LB), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause),
    .dir_valid(dir_valid), .dir_in(dir_in),
    .snakes(snakes), .lens(lens), .foods(foods), .alive(alive),
    .busy(busy), .step_done(step_done), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL-1:0] h0, h1;
    logic [LB-1:0] l0, l1;
    logic [NS-1:0] alive;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, done_count = 0;
  always @(posedge clk) if (step_done === 1'b1) done_count++;

  int mx[NS], my[NS], ml[NS];
  bit ma[NS];
  logic [1:0] md[NS];
  int fx[NF], fy[NF];
  bit fk[NF];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL-1:0] pos(input int x, input int y);
    return {5'(y), 5'(x)};
  endfunction

  function automatic logic [NL-1:0] seg_at(input int i, input int k);
    return snakes[(i*ML+k)*NL +: NL];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mx[i] = 3; my[i] = 2 + 3 * i; ml[i] = 2; ma[i] = 1'b1; md[i] = 2'b11;
    end
    for (int j = 0; j < NF; j++) begin
      fx[j] = W - 4; fy[j] = 3 + 3 * j; fk[j] = 1'b1;
    end
  endtask

  task automatic model_dir(input int i, input logic [1:0] d);
    if (d != (md[i] ^ 2'b01)) md[i] = d;
  endtask

  // kill marks snakes the directed scenario steers into a body collision on this step.
  task automatic model_step(input bit [NS-1:0] kill);
    exp_t e;
    for (int i = 0; i < NS; i++) begin
      int nx, ny;
      if (!ma[i]) continue;
      nx = mx[i]; ny = my[i];
      case (md[i])
        2'b00: ny--;
        2'b01: ny++;
        2'b10: nx--;
        default: nx++;
      endcase
      if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
`ifdef WRAP_EN
        mx[i] = (nx + W) % W; my[i] = (ny + H) % H;
`else
        ma[i] = 1'b0;
`endif
      end else begin
        mx[i] = nx; my[i] = ny;
      end
    end
    for (int i = 0; i < NS; i++) if (kill[i]) ma[i] = 1'b0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NF; j++)
        if (ma[i] && fk[j] && mx[i] == fx[j] && my[i] == fy[j]) begin
          if (ml[i] < ML) ml[i]++;
          fk[j] = 1'b0;
        end
    e.h0 = pos(mx[0], my[0]); e.h1 = pos(mx[1], my[1]);
    e.l0 = LB'(ml[0]);        e.l1 = LB'(ml[1]);
    e.alive = {ma[1], ma[0]};
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic set_dir(input int i, input logic [1:0] d);
    @(negedge clk); dir_valid[i] = 1'b1; dir_in[2*i +: 2] = d;
    @(negedge clk); dir_valid = '0;
    model_dir(i, d);
  endtask

  task automatic check_reset(input string tag);
    int bad = 0;
    for (int i = 0; i < NS; i++)
      for (int k = 0; k < ML; k++)
        if (seg_at(i, k) !== ((k == 0) ? pos(3, 2 + 3 * i) : (k == 1) ? pos(2, 2 + 3 * i) : 10'h3FF)) bad++;
    check({tag, "_segs"}, bad, 0);
    check({tag, "_lens"}, lens, {5'd2, 5'd2});
    check({tag, "_foods"}, foods, {pos(W - 4, 6), pos(W - 4, 3)});
    check({tag, "_alive"}, alive, 2'b11);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_step_done"}, step_done, 0);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  task automatic run_step(input bit chk_lat, input bit extra_tick, input bit [NS-1:0] kill);
    exp_t e;
    int cyc;
    bit busy_ok;
    model_step(kill);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    cyc = 1; busy_ok = 1'b1;
    while (step_done !== 1'b1 && cyc < 400) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick = (extra_tick && cyc == 10);
      @(negedge clk); cyc++;
    end
    tick = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    check("step_done_seen", step_done, 1);
    e = sb.pop_front();
    check("head0", seg_at(0, 0), e.h0);
    check("head1", seg_at(1, 0), e.h1);
    check("lens", lens, {e.l1, e.l0});
    check("alive", alive, e.alive);
    if (chk_lat) begin
      check("step_latency", cyc, STEP_LAT);
      check("busy_during_step", busy_ok, 1);
    end
  endtask

  initial begin
    int d0;
    logic [NL-1:0] f0;
    rst = 1'b0; tick = 1'b0; pause = 1'b0; dir_valid = '0; dir_in = '0;

    // Plain step from reset.
    do_reset();
    check_reset("t1_reset");
    run_step(1'b1, 1'b0, 2'b00);
    check("t1_seg1", seg_at(0, 1), pos(3, 2));
    check("t1_seg2_empty", seg_at(0, 2), 10'h3FF);
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_step_done_after", step_done, 0);

    // Reverse request dropped; ticks while busy or paused dropped.
    do_reset();
    set_dir(0, 2'b10);
    d0 = done_count;
    run_step(1'b1, 1'b1, 2'b00);
    repeat (50) @(negedge clk);
    check("t5_one_step", done_count, d0 + 1);
    pause = 1'b1;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (50) @(negedge clk);
    pause = 1'b0;
    repeat (50) @(negedge clk);
    check("t5_pause_no_step", done_count, d0 + 1);
    check("t5_pause_busy", busy, 0);
    check("t5_pause_head", seg_at(0, 0), pos(mx[0], my[0]));

    // Both snakes run into each other's bodies, then nothing moves.
    do_reset();
    set_dir(0, 2'b01);
    set_dir(1, 2'b00);
    run_step(1'b0, 1'b0, 2'b00);
    run_step(1'b0, 1'b0, 2'b11);
    check("t4_game_over", game_over, 1);
    run_step(1'b0, 1'b0, 2'b00);
    check("t4_seg0_1", seg_at(0, 1), pos(3, 3));
    check("t4_seg1_1", seg_at(1, 1), pos(3, 4));

    // Reset in the middle of the collision scan.
    do_reset();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (10) @(negedge clk);
    d0 = done_count;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    check_reset("t6_abort");
    repeat (50) @(negedge clk);
    check("t6_no_step_done", done_count, d0);

    // Steer snake0 onto food0 at (28,3) and grow.
    do_reset();
    set_dir(0, 2'b01);
    run_step(1'b0, 1'b0, 2'b00);
    set_dir(0, 2'b11);
    repeat (25) run_step(1'b0, 1'b0, 2'b00);
    check("t2_score", lens[4:0], 3);
    check("t2_seg1", seg_at(0, 1), pos(27, 3));
    check("t2_seg2", seg_at(0, 2), pos(26, 3));
    f0 = foods[NL-1:0];
    check("t2_food0_in_grid", (f0[9:5] < 5'(H)), 1);
    check("t2_food0_moved", (f0 != pos(28, 3)), 1);
    check("t2_food0_off_heads", (f0 != seg_at(0, 0)) && (f0 != seg_at(1, 0)), 1);
    check("t2_food1_kept", foods[2*NL-1:NL], pos(28, 6));

    // Right-hand wall: edge column reached, then one more step.
    do_reset();
    repeat (28) run_step(1'b0, 1'b0, 2'b00);
    check("t3_at_edge", seg_at(0, 0), pos(31, 2));
    run_step(1'b1, 1'b0, 2'b00);
`ifdef WRAP_EN
    check("t3_game_over", game_over, 0);
`else
    check("t3_game_over", game_over, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
